multi_cycle_ctr: RTL
====================

MULTI_CYCLE_CTR -- requirements
Module: multi_cycle_ctr

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  opcode field from the instruction register.
- func  in  6  function field from the instruction register.
- zero  in  1  ALU zero flag; valid in EX.
- mem_ready  in  1  memory completion handshake.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- ir_wr  out  1  instruction register load.
- pc_wr  out  1  PC update enable.
- pc_src  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- iord  out  1  memory address source: 0 = PC, 1 = ALU result register.
- reg_wr  out  1  register file write enable.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back source: 1 = memory data, 0 = ALU.
- alu_src  out  1  ALU B operand: 1 = immediate, 0 = register.
- ext_op  out  1  immediate extension: 1 = sign, 0 = zero.
- r_type  out  1  ALU operation taken from func.
- alu_op  out  4  ALU operation when r_type = 0: 0000 = add, 0001 = sub, 0010 = or.
- illegal  out  1  one-cycle pulse on an undecodable op.
- instr_cnt  out  32  retired-instruction count.
- state  out  3  current FSM state, for debug.

REQ-002 SHALL use one clock (clk); reset is synchronous and active-high (reset).

Function
REQ-003 SHALL implement the FSM states IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4; state codes 5-7 are unreachable and SHALL go to IF.
REQ-004 IF:
- Asserts mem_rd with iord = 0.
- Holds in IF while mem_ready = 0.
- When mem_ready = 1, pulses ir_wr and pc_wr with pc_src = 00, then moves to ID.
REQ-005 ID: decodes op and moves to the next state:
- j (000010): pc_wr = 1, pc_src = 10, then IF; retired.
- Legal ops other than j: moves to EX.
- Illegal op: illegal = 1 for one cycle, no write enables, then IF; not retired.
REQ-006 Legal ops are R-type (000000), lw (100011), sw (101011), beq (000100), bne (000101), j (000010), addi (001000) and ori (001101).
REQ-007 EX control settings:
- R-type: r_type = 1, alu_src = 0.
- lw, sw, addi: alu_op = add, alu_src = 1, ext_op = 1.
- ori: alu_op = or, alu_src = 1, ext_op = 0.
- beq, bne: alu_op = sub, alu_src = 0, ext_op = 1.
REQ-008 EX branch handling:
- pc_wr = zero for beq, and ~zero for bne, with pc_src = 01.
- Branches then return to IF and are retired.
- All other ops go to MEM (lw, sw) or WB (R-type, addi, ori).
REQ-009 MEM:
- iord = 1; mem_rd = 1 for lw, mem_wr = 1 for sw.
- Holds while mem_ready = 0.
- On mem_ready = 1: lw moves to WB; sw moves to IF and is retired.
REQ-010 WB:
- reg_wr = 1.
- reg_dst = 1 only for R-type.
- mem_to_reg = 1 only for lw.
- Then moves to IF; retired.
REQ-011 Every output not named for the current state/op SHALL be 0. Outputs are combinational from the registered state, op, func, zero and mem_ready.
REQ-012 Write enables (pc_wr, ir_wr, reg_wr, mem_wr) SHALL each assert for exactly one cycle per instruction. The exception is mem_wr, which holds high through MEM wait cycles.
REQ-013 Latency in cycles with zero wait states:
- j = 2.
- beq, bne = 3.
- R-type, addi, ori, sw = 4.
- lw = 5.
- Each mem_ready = 0 cycle adds one.
REQ-014 mem_ready is sampled only in IF and MEM and SHALL be ignored in all other states.

Reset
REQ-015 While reset = 1 at a clk edge, state SHALL become IF and instr_cnt SHALL become 0.
REQ-016 While reset = 1, all outputs except state SHALL be forced to 0. This includes mem_rd, so no request is issued during reset.
REQ-017 Reset asserted mid-instruction (including during a MEM wait) SHALL abandon that instruction without retiring it.

Configuration
REQ-018 Macro MULTI_CYCLE_CTR_PERF_CNT_EN controls the retired-instruction counter:
- Defined: instr_cnt increments by 1 on each retirement and wraps from 0xFFFFFFFF to 0.
- Undefined: instr_cnt is tied to 0 and no counter register is built.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then op = 000000 with mem_ready = 1 -> states 0,1,2,4,0; reg_wr = 1 and reg_dst = 1 in WB; instr_cnt = 1.
- lw with mem_ready low for 2 cycles in MEM -> 7 cycles total; mem_rd and iord held high in MEM; mem_to_reg = 1 in WB.
- beq with zero = 1, then beq with zero = 0 -> pc_wr = 1 with pc_src = 01 only for the first; each takes 3 cycles.
- op = 111111 -> illegal pulses for 1 cycle in ID; no write enables; instr_cnt unchanged.
- reset asserted during the MEM wait of sw -> mem_wr = 0 on the next cycle, state = IF, instr_cnt = 0.
- With the macro defined, instr_cnt preloaded to 0xFFFFFFFF, then one j -> instr_cnt = 0.

Source files
------------

// File: rtl/multi_cycle_ctr.sv
// multi_cycle_ctr: control FSM for a multi-cycle MIPS-style datapath (IF/ID/EX/MEM/WB).
// Latency: strobes are combinational from state and inputs; j=2, beq/bne=3, R/addi/ori/sw=4, lw=5 cycles.
// Backpressure: IF and MEM stall while mem_ready is low; mem_ready is ignored in ID, EX and WB.
// Option: define MULTI_CYCLE_CTR_PERF_CNT_EN to build the 32-bit retired-instruction counter.
module multi_cycle_ctr (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        reg_wr,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic        ext_op,
    output logic        r_type,
    output logic [3:0]  alu_op,
    output logic        illegal,
    output logic [31:0] instr_cnt,
    output logic [2:0]  state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   op_legal;

    // func is consumed by the ALU control downstream, not by this sequencer
    logic unused_func;
    assign unused_func = ^func;

    assign op_legal = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ORI};
    assign state    = state_q;

    // state register; reset always lands in IF
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state and datapath strobes; everything is gated off while reset is high
    always_comb begin
        state_d    = state_q;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        r_type     = 1'b0;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;

        case (state_q)
            ST_IF: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                if (op == OP_J) begin
                    pc_wr   = 1'b1;
                    pc_src  = 2'b10;
                    state_d = ST_IF;
                end else if (op_legal) begin
                    state_d = ST_EX;
                end else begin
                    illegal = 1'b1;
                    state_d = ST_IF;
                end
            end
            ST_EX: begin
                case (op)
                    OP_R: begin
                        r_type  = 1'b1;
                        state_d = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src = 1'b1;
                        ext_op  = 1'b1;
                        state_d = ST_MEM;
                    end
                    OP_ADDI: begin
                        alu_src = 1'b1;
                        ext_op  = 1'b1;
                        state_d = ST_WB;
                    end
                    OP_ORI: begin
                        alu_op  = ALU_OR;
                        alu_src = 1'b1;
                        state_d = ST_WB;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_op  = ALU_SUB;
                        ext_op  = 1'b1;
                        pc_src  = 2'b01;
                        pc_wr   = (op == OP_BEQ) ? zero : ~zero;
                        state_d = ST_IF;
                    end
                    // IR is stable after IF, so this only covers a corrupted opcode
                    default: state_d = ST_IF;
                endcase
            end
            ST_MEM: begin
                iord   = 1'b1;
                mem_rd = (op == OP_LW);
                mem_wr = (op == OP_SW);
                if (mem_ready) begin
                    state_d = (op == OP_LW) ? ST_WB : ST_IF;
                end
            end
            ST_WB: begin
                reg_wr     = 1'b1;
                reg_dst    = (op == OP_R);
                mem_to_reg = (op == OP_LW);
                state_d    = ST_IF;
            end
            default: state_d = ST_IF;
        endcase

        if (reset) begin
            state_d    = ST_IF;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            ir_wr      = 1'b0;
            pc_wr      = 1'b0;
            pc_src     = 2'b00;
            iord       = 1'b0;
            reg_wr     = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src    = 1'b0;
            ext_op     = 1'b0;
            r_type     = 1'b0;
            alu_op     = ALU_ADD;
            illegal    = 1'b0;
        end
    end

`ifdef MULTI_CYCLE_CTR_PERF_CNT_EN
    logic        retire;
    logic [31:0] instr_cnt_q;

    // an instruction retires on the last cycle of its route; illegal ops never do
    assign retire = ~reset &
                    (((state_q == ST_ID)  && (op == OP_J)) ||
                     ((state_q == ST_EX)  && ((op == OP_BEQ) || (op == OP_BNE))) ||
                     ((state_q == ST_MEM) && (op == OP_SW) && mem_ready) ||
                      (state_q == ST_WB));

    // free-running retirement count, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_cnt_q <= 32'd0;
        end else if (retire) begin
            instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign instr_cnt = instr_cnt_q;
`else
    assign instr_cnt = 32'd0;
`endif

endmodule
